// File: rtl/fp_pkg.sv
// Shared FP32 field constants and types for the float-to-int path.
// Used by the conversion core and the pipeline wrapper.
package fp_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;

   typedef enum logic {
      RM_RTZ = 1'b0,
      RM_RNE = 1'b1
   } rmode_e;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic inexact;
   } fp2int_flags_t;

endpackage

// File: rtl/fp2int_core.sv
// Combinational FP32 -> integer conversion: unpack, align, round,
// range-check on the magnitude, then negate or saturate.
module fp2int_core
   import fp_pkg::*;
#(
   parameter int OUT_W = 32
) (
   input  logic [31:0]      data,
   input  rmode_e           rmode,
   input  logic             sgn,
   output logic [OUT_W-1:0] result,
   output fp2int_flags_t    flags
);

   localparam int DW = OUT_W + 25;
   localparam int MW = MAN_W + 1;
   localparam int TW = MW + 25;

   localparam logic [DW-1:0] ONE  = DW'(1);
   localparam logic [DW-1:0] SPOS = (ONE << (OUT_W - 1)) - ONE;
   localparam logic [DW-1:0] SNEG = ONE << (OUT_W - 1);
   localparam logic [DW-1:0] UMAX = (ONE << OUT_W) - ONE;

   // Exponent at which the mantissa LSB has weight 1.
   localparam logic [EXP_W-1:0] POINT  = EXP_W'(EXP_BIAS + MAN_W);
   localparam logic [EXP_W-1:0] LCLAMP = EXP_W'(OUT_W + 1);
   localparam logic [EXP_W-1:0] RCLAMP = EXP_W'(25);

   logic                 s;
   logic [EXP_W-1:0]     e;
   logic [MAN_W-1:0]     f;
   logic                 is_nan;
   logic                 is_inf;
   logic [EXP_W-1:0]     e_eff;
   logic [EXP_W-1:0]     lsh;
   logic [EXP_W-1:0]     rsh;
   logic [MW-1:0]        m;
   logic [TW-1:0]        t;
   logic [DW-1:0]        mag;
   logic [DW-1:0]        rnd;
   logic [OUT_W-1:0]     lo;
   logic [OUT_W-1:0]     sat;
   logic                 guard;
   logic                 sticky;
   logic                 inc;
   logic                 ovf;

   assign s = data[31];
   assign e = data[30 -: EXP_W];
   assign f = data[MAN_W-1:0];

   always_comb begin
      result = '0;
      flags  = '0;
      is_nan = (e == '1) && (f != '0);
      is_inf = (e == '1) && (f == '0);
      e_eff  = (e == '0) ? EXP_W'(1) : e;
      m      = {e != '0, f};
      lsh    = e_eff - POINT;
      if (lsh > LCLAMP)
         lsh = LCLAMP;
      rsh    = POINT - e_eff;
      if (rsh > RCLAMP)
         rsh = RCLAMP;
      t      = {m, {(TW - MW){1'b0}}} >> rsh;
      if (e_eff >= POINT) begin
         mag    = DW'(m) << lsh;
         guard  = 1'b0;
         sticky = 1'b0;
      end else begin
         mag    = DW'(t[TW-1 -: MW]);
         guard  = t[TW-MW-1];
         sticky = |t[TW-MW-2:0];
      end
      inc = (rmode == RM_RNE) && guard && (sticky || mag[0]);
      rnd = mag + DW'(inc);
      lo  = rnd[OUT_W-1:0];
      // Range is judged on the magnitude so -2^(W-1) stays legal.
      if (sgn) begin
         ovf = s ? (rnd > SNEG) : (rnd > SPOS);
         sat = s ? SNEG[OUT_W-1:0] : SPOS[OUT_W-1:0];
      end else begin
         ovf = s ? (rnd != '0) : (rnd > UMAX);
         sat = s ? '0 : UMAX[OUT_W-1:0];
      end
      if (is_nan) begin
         result        = sgn ? SPOS[OUT_W-1:0] : UMAX[OUT_W-1:0];
         flags.invalid = 1'b1;
      end else if (is_inf || ovf) begin
         result         = sat;
         flags.overflow = 1'b1;
      end else begin
         result        = (s && sgn) ? -lo : lo;
         flags.inexact = guard | sticky;
      end
   end

endmodule

// File: rtl/fp2int_pipe.sv
// Fixed-latency FP32 -> integer converter: conversion feeds stage 1,
// remaining stages are pure delay; en freezes the whole pipe.
module fp2int_pipe
   import fp_pkg::*;
#(
   parameter int LATENCY = 6,
   parameter int OUT_W   = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_rmode,
   input  logic             in_signed,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [2:0]       out_flags
);

   logic [OUT_W-1:0] res;
   fp2int_flags_t    flg;

   logic             vld [LATENCY];
   logic [OUT_W-1:0] dat [LATENCY];
   fp2int_flags_t    fl  [LATENCY];

   fp2int_core #(
      .OUT_W (OUT_W)
   ) u_core (
      .data   (in_data),
      .rmode  (rmode_e'(in_rmode)),
      .sgn    (in_signed),
      .result (res),
      .flags  (flg)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld[i] <= 1'b0;
            dat[i] <= '0;
            fl[i]  <= '0;
         end
      end else if (en) begin
         vld[0] <= in_valid;
         dat[0] <= res;
         fl[0]  <= flg;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
            fl[i]  <= fl[i-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_data  = dat[LATENCY-1];
   assign out_flags = fl[LATENCY-1];

endmodule

// File: doc/fp2int_pipe.md
Name: fp2int_pipe

Overview:
- Synthesizable, parametrised FP32-to-integer converter with a configurable fixed latency.
- Successor to the DPI-backed converter: real RTL, configurable output width, per-transaction rounding and signedness, valid tracking, stall, exception flags.
- Sits in the shader ALU's conversion path; LATENCY defaults to 6 so it drops into existing 6-deep scoreboard timing.

Parameters:
- LATENCY, 6: accept-to-output cycles, counted in enabled cycles; legal range 1..16.
- OUT_W, 32: integer result width; legal range 8..64.

Ports:
- clock      in   1      rising-edge clock
- reset      in   1      synchronous, active-high
- en         in   1      pipeline advance; 0 freezes every stage
- in_valid   in   1      operand valid, sampled only when en=1
- in_data    in   32     IEEE-754 binary32 operand
- in_rmode   in   1      0=RTZ (truncate), 1=RNE (ties-to-even)
- in_signed  in   1      1=signed result, 0=unsigned result
- out_valid  out  1      result valid
- out_data   out  OUT_W  integer result
- out_flags  out  3      {invalid, overflow, inexact}

Behaviour:
- Interface: one clock "clock"; reset "reset" is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_flags=0, all internal stage valids 0.
- Reset mid-operation: all in-flight transactions are dropped at that edge. There is no partial output after reset.
- Pipeline:
  - LATENCY register stages; each carries valid, data, and flags.
  - Conversion logic (fp2int_core) feeds stage 1. Stages 2..LATENCY are pure delay.
  - Operand accepted at edge N (en=1) appears on outputs after edge N+LATENCY-1 when en is held high. Sustained throughput is 1 per enabled cycle.
- Stall: en=0 holds every stage register, including outputs. en does not gate reset.
- Bubbles: in_valid=0 still advances the pipe. Data/flags of invalid slots are don't-care, but the bench checks out_data only when out_valid=1.
- in_rmode and in_signed are per-transaction and travel with the operand.
- Conversion:
  - Unpack s, e (8 bits), f (23 bits).
  - Normal values: mantissa 1.f; subnormals: mantissa 0.f with exponent -126.
  - Align to an integer with guard and sticky bits.
  - RTZ drops the fraction. RNE increments on guard&(sticky|lsb).
  - inexact=1 whenever any discarded fraction bit is nonzero and the result is not saturated.
- Signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The rounded magnitude is range-checked *before* two's-complement negation.
  - Out of range: saturate to the nearest bound, overflow=1, inexact=0.
- Unsigned range [0, 2^OUT_W-1].
  - Negative value rounding to nonzero: result 0, overflow=1.
  - Negative value rounding to 0 (e.g. -0.3 RTZ): result 0, overflow=0, inexact=1.
- Special operands:
  - NaN: result = signed max (2^(OUT_W-1)-1) or unsigned max, invalid=1, other flags 0.
  - +Inf/-Inf: saturate per sign and signedness, overflow=1.
  - ±0: result 0, no flags. Subnormals become 0 (or 1/-1 never: |x|<2^-126), with inexact=1.
- Large exponents: shift amounts ≥ OUT_W+1 are clamped internally, so no shift exceeds the datapath width. The datapath width is OUT_W+25 bits.

Decomposition:
- Package fp_pkg holds:
  - FP32 field constants: EXP_BIAS=127, EXP_W=8, MAN_W=23.
  - typedef rmode_e {RM_RTZ, RM_RNE}.
  - packed struct fp2int_flags_t {invalid, overflow, inexact}.
- Sub-module fp2int_core: combinational unpack/align/round/saturate, parametrised by OUT_W.
- fp2int_pipe owns only the stage registers, valid, en, and reset.

Test Plan:
- Defaults, RNE, signed, back-to-back operands:
  - 0x40200000 (2.5) -> 0x00000002, flags 001.
  - 0x40600000 (3.5) -> 0x00000004, flags 001.
  - 0xBFC00000 (-1.5) -> 0xFFFFFFFE, flags 001.
  - All three appear on consecutive cycles exactly 6 cycles after acceptance.
- RTZ, signed:
  - 0xBFC00000 -> 0xFFFFFFFF, flags 001.
  - 0x4F32D05E (3e9) -> 0x7FFFFFFF, flags 010.
- RTZ, unsigned:
  - 0x4F32D05E -> 0xB2D05E00, flags 000.
  - 0xBF800000 (-1.0) -> 0, flags 010.
- Specials, signed:
  - 0x7FC00000 -> 0x7FFFFFFF, flags 100.
  - 0xFF800000 -> 0x80000000, flags 010.
  - 0x80000000 -> 0, flags 000.
  - 0x00000001 -> 0, flags 001.
- Stall and reset:
  - Accept 0x41200000 (10.0), then drop en for 3 cycles; outputs frozen, result 10 emerges at enabled-cycle 6.
  - Assert reset with 4 operands in flight; out_valid stays 0 and no stale result appears afterwards.
- Parameter sweep OUT_W=16, LATENCY=1:
  - 0x47000000 (32768.0) signed -> 0x7FFF, flags 010.
  - Same operand unsigned -> 0x8000, flags 000.
  - Result appears one edge after acceptance.
